// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - lamp-bus checker for a four-road junction (optional yellow timing: TLM_YELLOW_CHECK_EN)
module traffic_light_monitor #(
    parameter int YEL_MIN = 2,
    parameter int YEL_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  light_M1,
    input  logic [2:0]  light_S,
    input  logic [2:0]  light_MT,
    input  logic [2:0]  light_M2,
    input  logic        err_clr,
    output logic        err_encoding,
    output logic        err_sequence,
    output logic        err_conflict,
    output logic        err_yellow,
    output logic        fault,
    output logic [7:0]  err_count,
    output logic [15:0] phase_count
);

    // Lamp encodings: bit2 red, bit1 yellow, bit0 green
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Road indices into the packed bus arrays
    localparam int ROAD_M1 = 0;
    localparam int ROAD_S  = 1;
    localparam int ROAD_MT = 2;
    localparam int ROAD_M2 = 3;

    // A yellow window that cannot be met would make every yellow phase an error
    if (YEL_MIN > YEL_MAX) begin : g_bad_yel_window
        $error("traffic_light_monitor: YEL_MIN must not exceed YEL_MAX");
    end

    logic [3:0][2:0] cur_bus;
    logic [3:0][2:0] prev_bus;
    logic            first_q;

    logic [3:0]      legal;
    logic [3:0]      active;
    logic [3:0]      seq_bad;

    logic            enc_evt;
    logic            seq_evt;
    logic            con_evt;
    logic            yel_evt;
    logic            any_evt;
    logic            phase_evt;

    assign cur_bus = {light_M2, light_MT, light_S, light_M1};

    // Per-road decode: one-hot legality, active (green/yellow) and transition legality
    always_comb begin
        legal   = '0;
        active  = '0;
        seq_bad = '0;
        for (int i = 0; i < 4; i++) begin
            legal[i]  = (cur_bus[i] == LAMP_R) || (cur_bus[i] == LAMP_Y) ||
                        (cur_bus[i] == LAMP_G);
            active[i] = (cur_bus[i] == LAMP_G) || (cur_bus[i] == LAMP_Y);
            // prev_bus only ever holds legal values, so only the current value needs gating
            seq_bad[i] = legal[i] && !first_q &&
                         !((cur_bus[i] == prev_bus[i]) ||
                           (prev_bus[i] == LAMP_R && cur_bus[i] == LAMP_G) ||
                           (prev_bus[i] == LAMP_G && cur_bus[i] == LAMP_Y) ||
                           (prev_bus[i] == LAMP_Y && cur_bus[i] == LAMP_R));
        end
    end

    // Error events detected at this edge; M1 may run with M2 or MT, nothing may run with S
    always_comb begin
        enc_evt   = ~&legal;
        seq_evt   = |seq_bad;
        con_evt   = (active[ROAD_S] &&
                     (active[ROAD_M1] || active[ROAD_MT] || active[ROAD_M2])) ||
                    (active[ROAD_MT] && active[ROAD_M2]);
        any_evt   = enc_evt || seq_evt || con_evt || yel_evt;
        phase_evt = !first_q && (prev_bus[ROAD_M1] == LAMP_Y) &&
                    (cur_bus[ROAD_M1] == LAMP_R);
    end

    // Previous-value registers; the first sample after reset only seeds them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_bus <= {4{LAMP_R}};
            first_q  <= 1'b1;
        end else begin
            first_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (legal[i]) begin
                    prev_bus[i] <= cur_bus[i];
                end
            end
        end
    end

`ifdef TLM_YELLOW_CHECK_EN
    localparam int             YCW       = $clog2(YEL_MAX + 2);
    localparam logic [YCW-1:0] YCNT_MIN  = YCW'(YEL_MIN);
    localparam logic [YCW-1:0] YCNT_MAX  = YCW'(YEL_MAX);
    localparam logic [YCW-1:0] YCNT_SAT  = YCW'(YEL_MAX + 1);

    logic [3:0][YCW-1:0] ycnt_q;
    logic [3:0]          yel_bad;

    // Yellow too short at Y->R, or this sample is the first one past the maximum
    always_comb begin
        yel_bad = '0;
        for (int i = 0; i < 4; i++) begin
            yel_bad[i] = ((cur_bus[i] == LAMP_Y) && (ycnt_q[i] == YCNT_MAX)) ||
                         (!first_q && (prev_bus[i] == LAMP_Y) &&
                          (cur_bus[i] == LAMP_R) && (ycnt_q[i] < YCNT_MIN));
        end
    end

    assign yel_evt = |yel_bad;

    // Consecutive-yellow counters, saturating one past the legal maximum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ycnt_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cur_bus[i] == LAMP_Y) begin
                    if (ycnt_q[i] != YCNT_SAT) begin
                        ycnt_q[i] <= ycnt_q[i] + YCW'(1);
                    end
                end else begin
                    ycnt_q[i] <= '0;
                end
            end
        end
    end

    // Sticky yellow-timing flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_yellow <= 1'b0;
        end else if (err_clr) begin
            err_yellow <= yel_evt;
        end else begin
            err_yellow <= err_yellow | yel_evt;
        end
    end
`else
    assign yel_evt    = 1'b0;
    assign err_yellow = 1'b0;
`endif

    // Sticky flags; a clear at the same edge as a new event leaves that event visible
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_encoding <= 1'b0;
            err_sequence <= 1'b0;
            err_conflict <= 1'b0;
        end else if (err_clr) begin
            err_encoding <= enc_evt;
            err_sequence <= seq_evt;
            err_conflict <= con_evt;
        end else begin
            err_encoding <= err_encoding | enc_evt;
            err_sequence <= err_sequence | seq_evt;
            err_conflict <= err_conflict | con_evt;
        end
    end

    // Error-cycle counter, saturating at 255
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= {7'd0, any_evt};
        end else if (any_evt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    // Summary fault, one cycle behind the sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault <= 1'b0;
        end else begin
            fault <= err_encoding | err_sequence | err_conflict | err_yellow;
        end
    end

    // Completed M1 cycles, wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_count <= '0;
        end else if (phase_evt) begin
            phase_count <= phase_count + 16'd1;
        end
    end

endmodule
